// File: rtl/parity_seq_pkg.sv
// ============================================================================
// Module   : parity_seq_pkg
// Brief    : Shared state encoding for the parity frame sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package parity_seq_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DATA   = 2'd1;
    localparam logic [1:0] c_ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        DATA   = c_ST_DATA,
        PARITY = c_ST_PARITY
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/parity_accum.sv
// ============================================================================
// Module   : parity_accum
// Brief    : 1-bit XOR accumulator with synchronous clear and enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module parity_accum (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_bit,
    output logic o_parity
);

    logic r_parity;

    // Clear wins over enable so a load always starts from zero parity.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_parity <= 1'b0;
        end else if (i_clr) begin
            r_parity <= 1'b0;
        end else if (i_en) begin
            r_parity <= r_parity ^ i_bit;
        end
    end

    assign o_parity = r_parity;

endmodule

`default_nettype wire

// File: rtl/parity_frame_sequencer.sv
// ============================================================================
// Module   : parity_frame_sequencer
// Brief    : Loads a word, shifts it out LSB-first, then appends a parity beat.
//            Define PARITY_ODD_EN for odd parity (default build is even).
// Revision : 1.0
// ============================================================================
`default_nettype none

module parity_frame_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_bit,
    output logic             o_bit_valid,
    input  logic             i_bit_ready,
    output logic             o_last,
    output logic             o_busy
);

    import parity_seq_pkg::*;

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(WIDTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_beat;
    logic             w_parity;
    logic             w_par_bit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs decode from registered state only; i_valid/i_bit_ready steer
    // just the next state and the datapath strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_beat       = 1'b0;
        o_ready      = 1'b0;
        o_bit_valid  = 1'b0;
        o_bit        = 1'b0;
        o_last       = 1'b0;
        o_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_load       = 1'b1;
                    w_next_state = DATA;
                end
            end
            DATA: begin
                o_bit_valid = 1'b1;
                o_bit       = r_shift[0];
                o_busy      = 1'b1;
                if (i_bit_ready) begin
                    w_beat = 1'b1;
                    if (r_count == c_LAST_CNT) begin
                        w_next_state = PARITY;
                    end
                end
            end
            PARITY: begin
                o_bit_valid = 1'b1;
                o_bit       = w_par_bit;
                o_last      = 1'b1;
                o_busy      = 1'b1;
                if (i_bit_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_load) begin
            r_shift <= i_data;
            r_count <= '0;
        end else if (w_beat) begin
            r_shift <= {1'b0, r_shift[WIDTH-1:1]};
            r_count <= r_count + 1'b1;
        end
    end

    parity_accum u_accum (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_load),
        .i_en     (w_beat),
        .i_bit    (r_shift[0]),
        .o_parity (w_parity)
    );

`ifdef PARITY_ODD_EN
    assign w_par_bit = ~w_parity;
`else
    assign w_par_bit = w_parity;
`endif

endmodule

`default_nettype wire
